// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared definitions for the load/store unit. Holds the funct3
//               access-size codes, the internal size encoding and the
//               lane-offset helper used by both the top level and the lane
//               aligner.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  // funct3 access-size codes. Stores reuse the signed codes
  // (SB = LB, SH = LH, SW = LW).
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Size as carried in funct3[1:0].
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte lane of the access within the word. Halfword and word accesses
  // ignore the low address bits that do not select a lane.
  function automatic logic [1:0] lane_offset(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return addr_lo;
      SIZE_HALF: return {addr_lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational lane formatting for the load/store unit.
//               Store side: replicates the byte/half across all lanes and
//               builds the write strobe. Load side: selects the addressed
//               lane of the response word and sign/zero extends it.
// Ports       : i_st_size/i_st_addr_lo/i_st_data -> o_st_wdata, o_st_wstrb
//               i_ld_funct3/i_ld_addr_lo/i_ld_rdata -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_wstrb,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [1:0]  w_st_off;
  logic [1:0]  w_ld_off;
  logic [31:0] w_ld_shifted;
  logic        w_ld_sign;

  always_comb begin
    w_st_off   = lane_offset(i_st_size, i_st_addr_lo);
    o_st_wdata = i_st_data;
    o_st_wstrb = 4'b1111;
    case (i_st_size)
      SIZE_BYTE: begin
        o_st_wdata = {4{i_st_data[7:0]}};
        o_st_wstrb = 4'b0001 << w_st_off;
      end
      SIZE_HALF: begin
        o_st_wdata = {2{i_st_data[15:0]}};
        o_st_wstrb = 4'b0011 << w_st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ld_off     = lane_offset(i_ld_funct3[1:0], i_ld_addr_lo);
    // Move the addressed lane down to bit 0 before extension.
    w_ld_shifted = i_ld_rdata >> {w_ld_off, 3'b000};
    w_ld_sign    = 1'b0;
    o_ld_data    = w_ld_shifted;
    case (i_ld_funct3[1:0])
      SIZE_BYTE: begin
        w_ld_sign = ~i_ld_funct3[2] & w_ld_shifted[7];
        o_ld_data = {{24{w_ld_sign}}, w_ld_shifted[7:0]};
      end
      SIZE_HALF: begin
        w_ld_sign = ~i_ld_funct3[2] & w_ld_shifted[15];
        o_ld_data = {{16{w_ld_sign}}, w_ld_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle data-memory access stage. Takes the ALU result as
//               effective address and rs2 as store data, issues a
//               valid/ready request to data memory, formats loads/stores and
//               stalls the CPU while the access is in flight.
// Ports       : clk, reset (sync, active high)
//               mem_read/mem_write/funct3/addr/store_data  - instruction side
//               load_data/stall/done/access_err             - CPU side
//               mem_req_*  / mem_resp_*                     - memory side
// Macro       : LSU_MISALIGN_CHECK_EN - reject misaligned half/word accesses
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              access_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       load_data_q, load_data_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic              req_we_q, req_we_d;

  logic        w_req;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_accept;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [31:0] w_ld_data;

  // Store formatting uses the live instruction inputs so the request fields
  // are registered already formatted; load extraction uses the latched
  // lane and size against the response word.
  lsu_lane_align u_lane_align (
    .i_st_size    (funct3[1:0]),
    .i_st_addr_lo (addr[1:0]),
    .i_st_data    (store_data),
    .o_st_wdata   (w_st_wdata),
    .o_st_wstrb   (w_st_wstrb),
    .i_ld_funct3  (funct3_q),
    .i_ld_addr_lo (addr_lo_q),
    .i_ld_rdata   (mem_resp_rdata),
    .o_ld_data    (w_ld_data)
  );

  // ---------------------------------------------------------------- legality
  always_comb begin
    w_f3_ok = 1'b0;
    case (funct3)
      FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: w_f3_ok = 1'b1;
      // Unsigned size codes have no store counterpart.
      FUNCT3_LBU, FUNCT3_LHU:          w_f3_ok = mem_read;
      default:                         w_f3_ok = 1'b0;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((funct3[1:0] == SIZE_HALF) && addr[0]) ||
                      ((funct3[1:0] == SIZE_WORD) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req     = mem_read | mem_write;
  assign w_illegal = (mem_read & mem_write) | ~w_f3_ok | w_misalign;
  assign w_accept  = (state_q == ST_IDLE) & w_req & ~w_illegal;

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      load_data_q <= 32'd0;
      req_addr_q  <= '0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      req_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      load_data_q <= load_data_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      req_we_q    <= req_we_d;
    end
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (w_accept) state_d = ST_REQ;
      ST_REQ:       if (mem_req_ready) state_d = req_we_q ? ST_DONE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (mem_resp_valid) state_d = ST_DONE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    load_data_d = load_data_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    req_we_d    = req_we_q;
    if (w_accept) begin
      addr_lo_d   = addr[1:0];
      funct3_d    = funct3;
      req_addr_d  = {addr[ADDR_W-1:2], 2'b00};
      req_wdata_d = w_st_wdata;
      req_wstrb_d = w_st_wstrb;
      req_we_d    = mem_write;
    end
    if ((state_q == ST_WAIT_RESP) && mem_resp_valid) begin
      load_data_d = w_ld_data;
    end
  end

  // ----------------------------------------------------------------- outputs
  always_comb begin
    mem_req_valid = (state_q == ST_REQ);
    done          = (state_q == ST_DONE);
    access_err    = (state_q == ST_IDLE) & w_req & w_illegal;
    stall         = w_accept | (state_q == ST_REQ) | (state_q == ST_WAIT_RESP);
  end

  assign load_data     = load_data_q;
  assign mem_req_we    = req_we_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit. Drives
//               inputs two time units after each rising edge and samples one
//               unit later; memory is modelled by fixed ready/response timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, done, access_err;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int errors = 0;
  int checks = 0;

  // Request observations gathered by run_access.
  int          req_cycles;
  logic        req_unstable;
  logic [31:0] req_addr_s, req_wdata_s;
  logic [3:0]  req_wstrb_s;
  logic        req_we_s;
  logic        err_seen;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .funct3         (funct3),
    .addr           (addr),
    .store_data     (store_data),
    .load_data      (load_data),
    .stall          (stall),
    .done           (done),
    .access_err     (access_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    funct3         = 3'b000;
    addr           = 32'd0;
    store_data     = 32'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'd0;
  endtask

  // Issues one access, keeps mem_req_ready low for ready_wait REQ cycles,
  // returns the response one cycle after the handshake for loads. Bounded
  // to 40 cycles; returns with the DUT back in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int ready_wait, input logic [31:0] rdata,
                            output int n_cyc, output int n_stall, output logic got_done);
    int   waited;
    logic hs_now;
    mem_read      = rd;
    mem_write     = wr;
    funct3        = f3;
    addr          = a;
    store_data    = sd;
    mem_req_ready = (ready_wait == 0);
    waited        = 0;
    n_cyc         = 0;
    n_stall       = 0;
    got_done      = 1'b0;
    req_cycles    = 0;
    req_unstable  = 1'b0;
    err_seen      = 1'b0;
    while (!got_done && n_cyc < 40) begin
      #1;
      n_cyc++;
      if (stall) n_stall++;
      if (access_err) err_seen = 1'b1;
      if (done) got_done = 1'b1;
      if (mem_req_valid) begin
        if (req_cycles == 0) begin
          req_addr_s  = mem_req_addr;
          req_wdata_s = mem_req_wdata;
          req_wstrb_s = mem_req_wstrb;
          req_we_s    = mem_req_we;
        end else if (mem_req_addr !== req_addr_s || mem_req_wdata !== req_wdata_s ||
                     mem_req_wstrb !== req_wstrb_s || mem_req_we !== req_we_s) begin
          req_unstable = 1'b1;
        end
        req_cycles++;
      end
      hs_now = mem_req_valid && mem_req_ready;
      if (mem_req_valid && !mem_req_ready) waited++;
      step();
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_req_ready  = (waited >= ready_wait);
      mem_resp_valid = hs_now & rd;
      mem_resp_rdata = hs_now ? rdata : 32'd0;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data: got %h exp %h", load_data, 32'd0); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", mem_req_valid); end
    checks++; if (mem_req_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", mem_req_we); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (access_err !== 1'b0) begin errors++; $display("FAIL reset_access_err: got %b exp 0", access_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    checks++; if (mem_req_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_req_addr); end
    checks++; if (mem_req_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", mem_req_wdata); end
    checks++; if (mem_req_wstrb !== 4'd0) begin errors++; $display("FAIL reset_wstrb: got %b exp 0000", mem_req_wstrb); end
    step();
  endtask

  task automatic test_lw();
    int n_cyc, n_stall;
    logic got_done;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, n_cyc, n_stall, got_done);
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL lw_done: got %b exp 1", got_done); end
    checks++; if (n_cyc !== 4) begin errors++; $display("FAIL lw_latency: got %0d exp 4", n_cyc); end
    checks++; if (n_stall !== 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d exp 3", n_stall); end
    checks++; if (load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h exp DEADBEEF", load_data); end
    checks++; if (req_addr_s !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h exp 00000100", req_addr_s); end
    checks++; if (req_we_s !== 1'b0) begin errors++; $display("FAIL lw_we: got %b exp 0", req_we_s); end
    // Back in IDLE: done must have dropped and load_data must persist.
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lw_done_pulse: got %b exp 0", done); end
    step();
    checks++; if (load_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data_hold: got %h exp DEADBEEF", load_data); end
  endtask

  task automatic test_load_extend();
    // {funct3, addr, rdata, expected}
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] a   [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
    logic [31:0] rd  [5] = '{32'h80123456, 32'h80123456, 32'h80011234, 32'hF00D1234, 32'h00007F00};
    logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F};
    int n_cyc, n_stall;
    logic got_done;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b1, 1'b0, f3[i], a[i], 32'd0, 0, rd[i], n_cyc, n_stall, got_done);
      checks++;
      if (load_data !== exp[i] || got_done !== 1'b1)
        begin errors++; $display("FAIL load_extend_%0d: got %h done=%b exp %h", i, load_data, got_done, exp[i]); end
    end
  endtask

  task automatic test_stores();
    int n_cyc, n_stall;
    logic got_done;
    logic [31:0] ld_before;
    ld_before = load_data;
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'd0, n_cyc, n_stall, got_done);
    checks++; if (req_wdata_s !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h exp ABCDABCD", req_wdata_s); end
    checks++; if (req_wstrb_s !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b exp 1100", req_wstrb_s); end
    checks++; if (req_we_s !== 1'b1) begin errors++; $display("FAIL sh_we: got %b exp 1", req_we_s); end
    checks++; if (req_addr_s !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h exp 00000200", req_addr_s); end
    checks++; if (n_cyc !== 3 || got_done !== 1'b1) begin errors++; $display("FAIL sh_latency: got %0d done=%b exp 3", n_cyc, got_done); end
    checks++; if (n_stall !== 2) begin errors++; $display("FAIL sh_stall_cycles: got %0d exp 2", n_stall); end
    checks++; if (load_data !== ld_before) begin errors++; $display("FAIL store_keeps_load_data: got %h exp %h", load_data, ld_before); end
    run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 0, 32'd0, n_cyc, n_stall, got_done);
    checks++; if (req_wdata_s !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h exp A5A5A5A5", req_wdata_s); end
    checks++; if (req_wstrb_s !== 4'b0010) begin errors++; $display("FAIL sb_wstrb: got %b exp 0010", req_wstrb_s); end
  endtask

  task automatic test_sw_backpressure();
    int n_cyc, n_stall;
    logic got_done;
    run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 5, 32'd0, n_cyc, n_stall, got_done);
    checks++; if (n_stall !== 7) begin errors++; $display("FAIL sw_bp_stall_cycles: got %0d exp 7", n_stall); end
    checks++; if (n_cyc !== 8 || got_done !== 1'b1) begin errors++; $display("FAIL sw_bp_latency: got %0d done=%b exp 8", n_cyc, got_done); end
    checks++; if (req_cycles !== 6) begin errors++; $display("FAIL sw_bp_valid_cycles: got %0d exp 6", req_cycles); end
    checks++; if (req_unstable !== 1'b0) begin errors++; $display("FAIL sw_bp_hold: got unstable=%b exp 0", req_unstable); end
    checks++; if (req_wdata_s !== 32'hCAFEF00D || req_wstrb_s !== 4'b1111)
      begin errors++; $display("FAIL sw_bp_format: got %h/%b exp CAFEF00D/1111", req_wdata_s, req_wstrb_s); end
    checks++; if (req_addr_s !== 32'h300) begin errors++; $display("FAIL sw_bp_addr: got %h exp 00000300", req_addr_s); end
  endtask

  task automatic test_illegal();
    // {mem_read, mem_write, funct3}
    logic       rd [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] f3 [4] = '{3'b010, 3'b011, 3'b100, 3'b111};
    for (int i = 0; i < 4; i++) begin
      mem_read  = rd[i];
      mem_write = wr[i];
      funct3    = f3[i];
      addr      = 32'h100;
      #1;
      checks++;
      if (access_err !== 1'b1 || stall !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL illegal_%0d: got err=%b stall=%b done=%b exp 1/0/0", i, access_err, stall, done); end
      step();
      idle_inputs();
      #1;
      checks++;
      if (mem_req_valid !== 1'b0 || access_err !== 1'b0)
        begin errors++; $display("FAIL illegal_noreq_%0d: got valid=%b err=%b exp 0/0", i, mem_req_valid, access_err); end
      step();
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h101;
    #1;
    checks++; if (access_err !== 1'b1 || stall !== 1'b0)
      begin errors++; $display("FAIL misalign_err: got err=%b stall=%b exp 1/0", access_err, stall); end
    step();
    idle_inputs();
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL misalign_noreq: got %b exp 0", mem_req_valid); end
    step();
`else
    int n_cyc, n_stall;
    logic got_done;
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'h11223344, n_cyc, n_stall, got_done);
    checks++; if (req_addr_s !== 32'h100 || err_seen !== 1'b0)
      begin errors++; $display("FAIL misalign_addr: got %h err=%b exp 00000100/0", req_addr_s, err_seen); end
    checks++; if (load_data !== 32'h11223344) begin errors++; $display("FAIL misalign_word_lane: got %h exp 11223344", load_data); end
`endif
  endtask

  task automatic test_reset_mid();
    mem_read      = 1'b1;
    funct3        = 3'b010;
    addr          = 32'h100;
    mem_req_ready = 1'b1;
    step();                 // REQ, handshake this cycle
    mem_read = 1'b0;
    step();                 // WAIT_RESP, no response yet
    mem_req_ready = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_wait_stall: got %b exp 1", stall); end
    reset = 1'b1;
    step();
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h12345678;
    #1;
    checks++; if (done !== 1'b0 || stall !== 1'b0 || mem_req_valid !== 1'b0)
      begin errors++; $display("FAIL rst_mid_idle: got done=%b stall=%b valid=%b exp 0/0/0", done, stall, mem_req_valid); end
    step();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b exp 0", done); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL rst_mid_load_data: got %h exp 0", load_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_stores();
    test_sw_backpressure();
    test_illegal();
    test_misalign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
